clk_div_monitor: RTL

Checks the output of the 50%-duty odd/even clock dividers. It samples the divided clock in the source `clk` domain and measures its period and high time in `clk` cycles. It declares lock after a run of correct periods and flags period errors, duty errors and a stopped clock. It sits directly downstream of the divider and drives the clock-health status registers.

---
 rtl/clk_div_monitor_if.sv | 26 ++
 rtl/clk_div_monitor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if: groups the divided-clock input, the error-counter clear
// and the health/status outputs of clk_div_monitor.
// master: the side that supplies the divided clock and the clear (divider/CSR).
// slave : the monitor itself.
interface clk_div_monitor_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
);
  logic             clk_div_in;
  logic             clr;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output clk_div_in, clr,
    input  locked, err, period_o, high_o, err_cnt
  );

  modport slave (
    input  clk_div_in, clr,
    output locked, err, period_o, high_o, err_cnt
  );
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: samples a divided clock in the source clk domain, measures
// its period and high time, declares lock after LOCK_CNT consecutive good
// periods and flags period, duty and stopped-clock faults.
// Optional feature macro: CLK_DIV_MON_DUTY_CHK_EN. When defined, the high
// time is measured and checked; when undefined, only the period is checked
// and high_o reads 0.
// The interface instance must be built with the same CNT_W/ERR_W values.
module clk_div_monitor #(
  parameter int EXP_DIV  = 9,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 4 * EXP_DIV,
  parameter int ERR_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  clk_div_monitor_if.slave   mon
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  EXP_PER  = CNT_W'(EXP_DIV);
  localparam logic [CNT_W-1:0]  TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
  localparam logic [GOOD_W-1:0] LOCK_M1  = GOOD_W'(LOCK_CNT - 1);
  localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              s1_reg, s2_reg, s3_reg;
  logic              rise;
  logic [CNT_W-1:0]  per_cnt_reg;
  logic [CNT_W-1:0]  meas_hi;
  logic              duty_ok;
  logic              good;
  logic              timeout;
  logic              to_done_reg;
  logic [GOOD_W-1:0] good_cnt_reg, good_cnt_next;
  logic              err_reg, err_next;
  logic              load;
  logic [CNT_W-1:0]  period_reg;
  logic [CNT_W-1:0]  high_reg;
  logic [ERR_W-1:0]  err_cnt_reg;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= mon.clk_div_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~s3_reg;

  // Period counter: reloads to 1 on a rise, otherwise saturating count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_reg <= '0;
    end else if (rise) begin
      per_cnt_reg <= CNT_W'(1);
    end else if (per_cnt_reg != CNT_MAX) begin
      per_cnt_reg <= per_cnt_reg + CNT_W'(1);
    end
  end

`ifdef CLK_DIV_MON_DUTY_CHK_EN
  logic [CNT_W-1:0] hi_cnt_reg;

  // High-time counter: reloads on a rise, counts saturating while s2 is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt_reg <= '0;
    end else if (rise) begin
      hi_cnt_reg <= CNT_W'(1);
    end else if (s2_reg && (hi_cnt_reg != CNT_MAX)) begin
      hi_cnt_reg <= hi_cnt_reg + CNT_W'(1);
    end
  end

  assign meas_hi = hi_cnt_reg;
  // The divider's half-cycle phase makes either floor or ceil legal.
  assign duty_ok = (hi_cnt_reg == CNT_W'(EXP_DIV / 2)) ||
                   (hi_cnt_reg == CNT_W'((EXP_DIV + 1) / 2));
`else
  assign meas_hi = '0;
  assign duty_ok = 1'b1;
`endif

  // Measured values are the counters as they stand during the rise cycle.
  assign good    = (per_cnt_reg == EXP_PER) && duty_ok;
  // A stalled clock reports once; to_done_reg re-arms on the next rise.
  assign timeout = (per_cnt_reg == TO_VAL) && !rise && !to_done_reg;

  // Timeout one-shot flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_done_reg <= 1'b0;
    end else if (rise) begin
      to_done_reg <= 1'b0;
    end else if (timeout) begin
      to_done_reg <= 1'b1;
    end
  end

  // FSM state, good-period run length and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      good_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
      err_reg      <= err_next;
    end
  end

  // Next-state logic: timeout overrides, otherwise act on each rise.
  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    err_next      = 1'b0;
    load          = 1'b0;
    if (timeout) begin
      state_next    = IDLE;
      good_cnt_next = '0;
      err_next      = (state_reg != IDLE);
    end else if (rise) begin
      case (state_reg)
        IDLE: begin
          // First edge only opens the measurement window.
          state_next    = ACQ;
          good_cnt_next = '0;
        end
        ACQ: begin
          load = 1'b1;
          if (good) begin
            good_cnt_next = good_cnt_reg + GOOD_ONE;
            if (good_cnt_reg == LOCK_M1) begin
              state_next = LOCKED;
            end
          end else begin
            err_next      = 1'b1;
            good_cnt_next = '0;
          end
        end
        LOCKED: begin
          load = 1'b1;
          if (!good) begin
            err_next      = 1'b1;
            good_cnt_next = '0;
            state_next    = ACQ;
          end
        end
        default: begin
          state_next    = IDLE;
          good_cnt_next = '0;
        end
      endcase
    end
  end

  // Measured period/high-time holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_reg <= '0;
      high_reg   <= '0;
    end else if (load) begin
      period_reg <= per_cnt_reg;
      high_reg   <= meas_hi;
    end
  end

  // Saturating fault counter; clear takes priority over a coincident fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (mon.clr) begin
      err_cnt_reg <= '0;
    end else if (err_next && (err_cnt_reg != ERR_MAX)) begin
      err_cnt_reg <= err_cnt_reg + ERR_W'(1);
    end
  end

  assign mon.locked   = (state_reg == LOCKED);
  assign mon.err      = err_reg;
  assign mon.period_o = period_reg;
  assign mon.high_o   = high_reg;
  assign mon.err_cnt  = err_cnt_reg;

endmodule
